// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: streams operands LSB-first through an
// external 1-bit full adder and assembles the N-bit result, final carry and overflow.
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         fa_x,
    output logic         fa_y,
    output logic         fa_cin,
    input  logic         fa_s,
    input  logic         fa_cout,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ra_q, ra_d;
    logic [N-1:0]    rb_q, rb_d;
    logic [N-1:0]    sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Subtraction is a + ~b + 1, so the inversion and forced carry-in happen at capture.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        fa_x    = 1'b0;
        fa_y    = 1'b0;
        fa_cin  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy    = 1'b1;
                fa_x    = ra_q[0];
                fa_y    = rb_q[0];
                fa_cin  = carry_q;
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                sum_d   = {fa_s, sum_q[N-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                // Overflow compares the carry into the MSB with the carry out of it.
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder on the fa_* ports
// and an arithmetic reference model for the random operations.
module tb_serial_add_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         fa_x;
    logic         fa_y;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   faRes;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .fa_x    (fa_x),
        .fa_y    (fa_y),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf)
    );

    assign faRes   = {1'b0, fa_x} + {1'b0, fa_y} + {1'b0, fa_cin};
    assign fa_s    = faRes[0];
    assign fa_cout = faRes[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned result/carry and signed overflow from integer arithmetic.
    task automatic refModel(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rsub,
                            input logic rcin, output logic [N-1:0] eSum, output logic eCout,
                            output logic eOvf);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(ra);
        ub = int'(rb);
        sa = ua >= 128 ? ua - 256 : ua;
        sb = ub >= 128 ? ub - 256 : ub;
        if (rsub) begin
            ures  = ua - ub;
            sres  = sa - sb;
            eCout = (ua >= ub);
        end else begin
            ures  = ua + ub + int'(rcin);
            sres  = sa + sb + int'(rcin);
            eCout = (ures > 255);
        end
        eSum = N'(ures & 255);
        eOvf = (sres > 127) || (sres < -128);
    endtask

    // One full operation: busy for N cycles, one DONE cycle, then IDLE.
    task automatic applyStimulus(input string tag, input logic [N-1:0] opA, input logic [N-1:0] opB,
                                 input logic opSub, input logic opCin, input logic [N-1:0] eSum,
                                 input logic eCout, input logic eOvf, input int repulseAt);
        @(negedge clk);
        a = opA; b = opB; sub = opSub; cin = opCin; start = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
            checkOutput({tag, ".doneLow"}, 32'(done), 32'd0);
            if (k == repulseAt) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else if (k == repulseAt + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".busyLow"}, 32'(busy), 32'd0);
        checkOutput({tag, ".sum"}, 32'(sum), 32'(eSum));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(eCout));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eOvf));
        checkOutput({tag, ".faIdle"}, 32'({fa_x, fa_y, fa_cin}), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".doneDrop"}, 32'(done), 32'd0);
        checkOutput({tag, ".busyIdle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".sumHold"}, 32'(sum), 32'(eSum));
        checkOutput({tag, ".coutHold"}, 32'(cout), 32'(eCout));
    endtask

    initial begin
        logic [N-1:0] rA, rB, eSum;
        logic         rSub, rCin, eCout, eOvf;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #2;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.sum", 32'(sum), 32'd0);
        checkOutput("reset.coutOvf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add0F01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, -1);
        applyStimulus("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        applyStimulus("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, -1);
        applyStimulus("sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
        applyStimulus("addCin", 8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, -1);
        applyStimulus("repulse", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 3);
        applyStimulus("sub8001", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, -1);

        // Abort mid-operation; cout/ovf are 1 from the previous op, so clearing is visible.
        @(negedge clk);
        a = 8'h33; b = 8'h44; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.sum", 32'(sum), 32'd0);
        checkOutput("abort.cout", 32'(cout), 32'd0);
        checkOutput("abort.ovf", 32'(ovf), 32'd0);
        checkOutput("abort.fa", 32'({fa_x, fa_y, fa_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            checkOutput("abort.noDone", 32'(done), 32'd0);
        end
        applyStimulus("afterReset", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            rA   = N'($urandom_range(0, 255));
            rB   = N'($urandom_range(0, 255));
            rSub = 1'($urandom_range(0, 1));
            rCin = 1'($urandom_range(0, 1));
            refModel(rA, rB, rSub, rCin, eSum, eCout, eOvf);
            applyStimulus($sformatf("rand%0d", i), rA, rB, rSub, rCin, eSum, eCout, eOvf, -1);
        end

        // Held start: one operation accepted per N+2 cycles.
        @(negedge clk);
        a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checkOutput($sformatf("held.done%0d", k), 32'(done), 32'((k % (N + 2)) == N + 1));
            checkOutput($sformatf("held.busy%0d", k), 32'(busy),
                        32'(((k % (N + 2)) >= 1) && ((k % (N + 2)) <= N)));
            if (done) checkOutput($sformatf("held.sum%0d", k), 32'(sum), 32'h02);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low; all state is cleared while low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: sub  input  1  operation select: 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 Port: cin  input  1  carry-in for add; ignored when sub=1.
REQ-007 Port: a  input  N  operand A; sampled with start.
REQ-008 Port: b  input  N  operand B; sampled with start.
REQ-009 Port: fa_x  output  1  to external 1-bit full adder, x input.
REQ-010 Port: fa_y  output  1  to external 1-bit full adder, y input.
REQ-011 Port: fa_cin  output  1  to external 1-bit full adder, cin input.
REQ-012 Port: fa_s  input  1  from external full adder, sum output (combinational from fa_x/fa_y/fa_cin).
REQ-013 Port: fa_cout  input  1  from external full adder, carry output.
REQ-014 Port: busy  output  1  high while bits are being processed.
REQ-015 Port: done  output  1  single-cycle pulse when the result is valid.
REQ-016 Port: sum  output  N  result register.
REQ-017 Port: cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-018 Port: ovf  output  1  signed overflow of the last operation.

Function
REQ-019 FSM states: IDLE, ADD, DONE; state, operand shift registers, carry register, bit counter (ceil(log2 N) bits), sum, cout and ovf are all registers.
REQ-020 IDLE with start=1 at a rising edge: capture ra=a, rb=(sub ? ~b : b), carry=(sub ? 1 : cin), counter=0, clear sum; next state ADD.
REQ-021 IDLE with start=0: remain in IDLE; sum, cout and ovf hold their last values.
REQ-022 In ADD, fa_x=ra[0], fa_y=rb[0] and fa_cin=carry, driven combinationally from registers; in IDLE and DONE all three are 0.
REQ-023 Each ADD edge: ra and rb shift right one bit; fa_s shifts into sum at bit N-1 (LSB ends at bit 0 after N cycles); carry<=fa_cout; counter increments.
REQ-024 On the ADD edge where counter==N-1: cout<=fa_cout; ovf<=carry XOR fa_cout (carry into MSB vs. carry out); next state DONE.
REQ-025 Latency: after start is sampled at edge E0, ADD occupies exactly N cycles; DONE occupies the cycle after edge EN; IDLE is re-entered after edge EN+1.
REQ-026 busy=1 exactly in ADD; done=1 exactly in DONE (one cycle); both are decoded from state.
REQ-027 start is ignored in ADD and DONE; operand inputs changing during ADD have no effect.
REQ-028 sum, cout and ovf are stable from the DONE cycle until the next accepted start, at which point sum clears to 0 and cout/ovf hold until final-bit update.
REQ-029 Back-to-back: start held high continuously yields one operation every N+2 cycles (accepted in each IDLE visit).
REQ-030 Arithmetic is modulo 2^N; sum = a + b + cin (add) or a + ~b + 1 (subtract), truncated to N bits.

Reset
REQ-031 rst_n=0 forces, immediately and regardless of clk: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, fa_x/fa_y/fa_cin=0, counter, carry and shift registers=0.
REQ-032 Reset asserted mid-ADD aborts the operation with no done pulse; the first start after rst_n rises is accepted normally.

Verification (N=8; the bench instantiates a behavioral 1-bit full adder on fa_* ports)
REQ-033 a=8'h0F, b=8'h01, cin=0, sub=0 -> busy high for 8 cycles, done one cycle later, sum=8'h10, cout=0, ovf=0.
REQ-034 a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-035 a=8'h05, b=8'h07, sub=1, cin=1 (must be ignored) -> sum=8'hFE, cout=0 (borrow), ovf=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
REQ-036 start re-pulsed with a=8'hAA, b=8'h55 during ADD of 8'h0F+8'h01 -> ignored; result 8'h10; no extra done.
REQ-037 rst_n driven low mid-cycle during the 4th ADD cycle -> busy, done, sum, cout and ovf go 0 before the next clk edge; a subsequent start with 8'h03+8'h04 gives sum=8'h07.
REQ-038 start held high for 30 cycles with a=8'h01, b=8'h01 -> done pulses exactly every 10 cycles, each with sum=8'h02.
